ex_stage: RTL and testbench

//  Execute stage. Consumes the ID/EX pipeline register outputs and computes the ALU result, load/store

---
 rtl/ex_stage_pkg.sv | 58 +++++
 rtl/ex_stage_div_unit.sv | 101 ++++++++++
 rtl/ex_stage.sv | 126 ++++++++++++
 tb/tb_ex_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared EX-stage definitions: ALU operation codes, result classes and divider state encodings.
package ex_stage_pkg;

   localparam int DIV_STEPS = 32;
   localparam int CNT_W     = $clog2(DIV_STEPS);

   localparam logic [7:0] EXE_NOP_OP    = 8'h00;
   localparam logic [7:0] EXE_AND_OP    = 8'h01;
   localparam logic [7:0] EXE_OR_OP     = 8'h02;
   localparam logic [7:0] EXE_XOR_OP    = 8'h03;
   localparam logic [7:0] EXE_SLL_OP    = 8'h04;
   localparam logic [7:0] EXE_SRL_OP    = 8'h05;
   localparam logic [7:0] EXE_SRA_OP    = 8'h06;
   localparam logic [7:0] EXE_ADD_OP    = 8'h07;
   localparam logic [7:0] EXE_SUB_OP    = 8'h08;
   localparam logic [7:0] EXE_SLT_OP    = 8'h09;
   localparam logic [7:0] EXE_SLTU_OP   = 8'h0A;
   localparam logic [7:0] EXE_JAL_OP    = 8'h0B;
   localparam logic [7:0] EXE_JALR_OP   = 8'h0C;
   localparam logic [7:0] EXE_LW_OP     = 8'h0F;
   localparam logic [7:0] EXE_SW_OP     = 8'h14;
   localparam logic [7:0] EXE_MUL_OP    = 8'h20;
   localparam logic [7:0] EXE_MULH_OP   = 8'h21;
   localparam logic [7:0] EXE_MULHSU_OP = 8'h22;
   localparam logic [7:0] EXE_MULHU_OP  = 8'h23;
   localparam logic [7:0] EXE_DIV_OP    = 8'h24;
   localparam logic [7:0] EXE_DIVU_OP   = 8'h25;
   localparam logic [7:0] EXE_REM_OP    = 8'h26;
   localparam logic [7:0] EXE_REMU_OP   = 8'h27;

   localparam logic [2:0] EXE_RES_NOP        = 3'd0;
   localparam logic [2:0] EXE_RES_LOGIC      = 3'd1;
   localparam logic [2:0] EXE_RES_SHIFT      = 3'd2;
   localparam logic [2:0] EXE_RES_ARITH      = 3'd3;
   localparam logic [2:0] EXE_RES_JUMP       = 3'd4;
   localparam logic [2:0] EXE_RES_LOAD_STORE = 3'd5;
   localparam logic [2:0] EXE_RES_MULDIV     = 3'd6;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'd0,
      DIV_BY_ZERO = 2'd1,
      DIV_ON      = 2'd2,
      DIV_END     = 2'd3
   } div_state_e;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;

   function automatic logic is_div_op(input logic [7:0] op);
      return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP) || (op == EXE_REM_OP) || (op == EXE_REMU_OP);
   endfunction

   function automatic logic is_md_op(input logic [7:0] op);
      return (op == EXE_MUL_OP) || (op == EXE_MULH_OP) || (op == EXE_MULHSU_OP) ||
             (op == EXE_MULHU_OP) || is_div_op(op);
   endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider, one quotient bit per clock; result_o = {remainder, quotient}.
// Only built when MULDIV_EN is defined.
`ifdef MULDIV_EN
module div_unit
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic        signed_div_i,
   input  logic        annul_i,
   input  logic [31:0] opdata1_i,
   input  logic [31:0] opdata2_i,
   output logic [63:0] result_o,
   output logic        ready_o
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
   logic             s1, s2;
   logic [31:0]      abs1, abs2, quo_fix, rem_fix;
   logic [32:0]      shifted, diff;

   assign s1      = signed_div_i & opdata1_i[31];
   assign s2      = signed_div_i & opdata2_i[31];
   assign abs1    = s1 ? -opdata1_i : opdata1_i;
   assign abs2    = s2 ? -opdata2_i : opdata2_i;
   assign shifted = {rem_q, quo_q[31]};
   assign diff    = shifted - {1'b0, dvs_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dz_d    = dz_q;
      ready_o = DIV_RESULT_NOT_READY;
      case (state_q)
         DIV_FREE: begin
            if (start_i) begin
               dz_d    = (opdata2_i == '0);
               qneg_d  = s1 ^ s2;
               rneg_d  = s1;
               dvs_d   = abs2;
               quo_d   = abs1;
               cnt_d   = '0;
               // Divide-by-zero skips the iterations: remainder is the dividend itself.
               rem_d   = (opdata2_i == '0) ? abs1 : '0;
               state_d = (opdata2_i == '0) ? DIV_END : DIV_ON;
            end
         end
         DIV_ON: begin
            if (shifted >= {1'b0, dvs_q}) begin
               rem_d = diff[31:0];
               quo_d = {quo_q[30:0], 1'b1};
            end else begin
               rem_d = shifted[31:0];
               quo_d = {quo_q[30:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DIV_STEPS - 1)) state_d = DIV_END;
         end
         DIV_END: begin
            ready_o = DIV_RESULT_READY;
            state_d = DIV_FREE;
         end
         default: state_d = DIV_FREE;
      endcase
      if (annul_i) state_d = DIV_FREE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DIV_FREE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      dz_q   <= dz_d;
   end

   assign quo_fix  = dz_q ? '1 : (qneg_q ? -quo_q : quo_q);
   assign rem_fix  = rneg_q ? -rem_q : rem_q;
   assign result_o = {rem_fix, quo_fix};

endmodule
`endif

// File: rtl/ex_stage.sv
// RV32 execute stage: ALU, load/store address, link value and optional RV32M mul/div.
// Define MULDIV_EN to build the M extension (single-cycle multiply, iterative div_unit).
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic        mem_ce_i,
   input  logic [31:0] mem_sdata_i,
   input  logic [31:0] branch_link_addr_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic [7:0]  aluop_o,
   output logic        mem_ce_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_sdata_o,
   output logic        stallreq_o
);

   logic [31:0] op_res, res, md_res;
   logic        div_stall, md_wreg;

   always_comb begin
      op_res = '0;
      case (aluop_i)
         EXE_AND_OP:  op_res = reg1_i & reg2_i;
         EXE_OR_OP:   op_res = reg1_i | reg2_i;
         EXE_XOR_OP:  op_res = reg1_i ^ reg2_i;
         EXE_SLL_OP:  op_res = reg1_i << reg2_i[4:0];
         EXE_SRL_OP:  op_res = reg1_i >> reg2_i[4:0];
         EXE_SRA_OP:  op_res = $signed(reg1_i) >>> reg2_i[4:0];
         EXE_ADD_OP:  op_res = reg1_i + reg2_i;
         EXE_SUB_OP:  op_res = reg1_i - reg2_i;
         EXE_SLT_OP:  op_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
         EXE_SLTU_OP: op_res = {31'b0, reg1_i < reg2_i};
         default:     op_res = '0;
      endcase
   end

`ifdef MULDIV_EN
   logic signed [63:0] mul_a, mul_b, prod;
   logic [63:0]        div_result;
   logic               div_ready, is_div, div_signed;

   // One 64x64 multiplier covers all four variants via per-operand sign/zero extension.
   assign mul_a = (aluop_i == EXE_MULHU_OP) ? {32'b0, reg1_i} : {{32{reg1_i[31]}}, reg1_i};
   assign mul_b = (aluop_i == EXE_MUL_OP || aluop_i == EXE_MULH_OP) ?
                  {{32{reg2_i[31]}}, reg2_i} : {32'b0, reg2_i};
   assign prod  = mul_a * mul_b;

   assign is_div     = is_div_op(aluop_i);
   assign div_signed = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_REM_OP);

   div_unit u_div (
      .clk         (clk),
      .rst         (rst),
      .start_i     (is_div & ~flush),
      .signed_div_i(div_signed),
      .annul_i     (flush),
      .opdata1_i   (reg1_i),
      .opdata2_i   (reg2_i),
      .result_o    (div_result),
      .ready_o     (div_ready)
   );

   always_comb begin
      md_res = '0;
      case (aluop_i)
         EXE_MUL_OP:                              md_res = prod[31:0];
         EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP: md_res = prod[63:32];
         EXE_DIV_OP, EXE_DIVU_OP:                 md_res = div_result[31:0];
         EXE_REM_OP, EXE_REMU_OP:                 md_res = div_result[63:32];
         default:                                 md_res = '0;
      endcase
   end

   assign div_stall = is_div & ~div_ready & ~flush;
   assign md_wreg   = wreg_i & (~is_div | (div_ready & ~flush));
`else
   logic unused_ctl;
   assign unused_ctl = ^{clk, flush};
   assign md_res     = '0;
   assign div_stall  = 1'b0;
   assign md_wreg    = 1'b0;
`endif

   always_comb begin
      res = '0;
      case (alusel_i)
         EXE_RES_LOGIC, EXE_RES_SHIFT, EXE_RES_ARITH: res = op_res;
         EXE_RES_JUMP:                                res = branch_link_addr_i;
         EXE_RES_MULDIV:                              res = md_res;
         default:                                     res = '0;
      endcase
   end

   always_comb begin
      wd_o        = wd_i;
      aluop_o     = aluop_i;
      mem_ce_o    = mem_ce_i;
      mem_addr_o  = reg1_i + reg2_i;
      mem_sdata_o = mem_sdata_i;
      wdata_o     = res;
      stallreq_o  = div_stall;
      wreg_o      = is_md_op(aluop_i) ? md_wreg : wreg_i;
      if (rst) begin
         wd_o        = '0;
         aluop_o     = '0;
         mem_ce_o    = 1'b0;
         mem_addr_o  = '0;
         mem_sdata_o = '0;
         wdata_o     = '0;
         stallreq_o  = 1'b0;
         wreg_o      = 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic [7:0]  aluop_i, aluop_o;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i, reg2_i, mem_sdata_i, branch_link_addr_i;
   logic [4:0]  wd_i, wd_o;
   logic        wreg_i, mem_ce_i, wreg_o, mem_ce_o, stallreq_o;
   logic [31:0] wdata_o, mem_addr_o, mem_sdata_o;

   int checks = 0;
   int errors = 0;
   logic [7:0] sc_ops [18];

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .wd_i(wd_i), .wreg_i(wreg_i), .mem_ce_i(mem_ce_i), .mem_sdata_i(mem_sdata_i),
      .branch_link_addr_i(branch_link_addr_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .aluop_o(aluop_o),
      .mem_ce_o(mem_ce_o), .mem_addr_o(mem_addr_o), .mem_sdata_o(mem_sdata_o),
      .stallreq_o(stallreq_o)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] sel_of(input logic [7:0] op);
      case (op)
         EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP:             return EXE_RES_LOGIC;
         EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP:            return EXE_RES_SHIFT;
         EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP, EXE_SLTU_OP: return EXE_RES_ARITH;
         EXE_JAL_OP, EXE_JALR_OP:                       return EXE_RES_JUMP;
         EXE_LW_OP, EXE_SW_OP:                          return EXE_RES_LOAD_STORE;
         EXE_NOP_OP:                                    return EXE_RES_NOP;
         default:                                       return EXE_RES_MULDIV;
      endcase
   endfunction

   function automatic logic [31:0] ref_res(input logic [7:0] op, input logic [31:0] a, b, link);
      longint sa, sb, ua, ub, p;
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      ub = b;
      p  = 0;
      case (op)
         EXE_AND_OP:  return a & b;
         EXE_OR_OP:   return a | b;
         EXE_XOR_OP:  return a ^ b;
         EXE_SLL_OP:  return a << b[4:0];
         EXE_SRL_OP:  return a >> b[4:0];
         EXE_SRA_OP:  begin p = sa >>> b[4:0]; return p[31:0]; end
         EXE_ADD_OP:  begin p = ua + ub; return p[31:0]; end
         EXE_SUB_OP:  begin p = ua - ub; return p[31:0]; end
         EXE_SLT_OP:  return (sa < sb) ? 32'd1 : 32'd0;
         EXE_SLTU_OP: return (ua < ub) ? 32'd1 : 32'd0;
         EXE_JAL_OP, EXE_JALR_OP: return link;
`ifdef MULDIV_EN
         EXE_MUL_OP:    begin p = sa * sb; return p[31:0]; end
         EXE_MULH_OP:   begin p = sa * sb; return p[63:32]; end
         EXE_MULHSU_OP: begin p = sa * ub; return p[63:32]; end
         EXE_MULHU_OP:  begin p = ua * ub; return p[63:32]; end
         EXE_DIV_OP:    begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
         EXE_DIVU_OP:   begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
         EXE_REM_OP:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         EXE_REMU_OP:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
`endif
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic ref_wreg(input logic [7:0] op, input logic w);
`ifdef MULDIV_EN
      return w;
`else
      return is_md_op(op) ? 1'b0 : w;
`endif
   endfunction

   function automatic logic [31:0] rand_val();
      logic [31:0] edges [4];
      edges = '{32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF};
      return ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
   endfunction

   // One single-cycle operation: drive after the edge, check outputs on the falling edge.
   task automatic single(input logic [7:0] op, input logic [31:0] a, b);
      logic [31:0] link, exp_addr;
      @(posedge clk); #1;
      aluop_i = op; alusel_i = sel_of(op); reg1_i = a; reg2_i = b;
      wd_i = 5'($urandom); wreg_i = 1'($urandom); mem_ce_i = 1'($urandom);
      mem_sdata_i = $urandom; link = $urandom; branch_link_addr_i = link;
      exp_addr = a + b;
      @(negedge clk);
      check($sformatf("wdata_op%02h", op), wdata_o, ref_res(op, a, b, link));
      check($sformatf("wreg_op%02h", op), wreg_o, ref_wreg(op, wreg_i));
      check($sformatf("stall_op%02h", op), stallreq_o, 0);
      check($sformatf("addr_op%02h", op), mem_addr_o, exp_addr);
      check("pass_through", {wd_o, mem_ce_o, aluop_o, mem_sdata_o}, {wd_i, mem_ce_i, op, mem_sdata_i});
   endtask

`ifdef MULDIV_EN
   task automatic run_div(input logic [7:0] op, input logic [31:0] a, b);
      int stalls, bad_wreg, exp_stalls;
      bit done;
      logic [31:0] exp;
      exp = ref_res(op, a, b, 32'h0);
      exp_stalls = (b == 0) ? 1 : 33;
      @(posedge clk); #1;
      aluop_i = op; alusel_i = EXE_RES_MULDIV; reg1_i = a; reg2_i = b; wreg_i = 1'b1;
      stalls = 0; bad_wreg = 0; done = 0;
      for (int c = 0; c < 80 && !done; c++) begin
         @(negedge clk);
         if (stallreq_o) begin
            stalls++;
            if (wreg_o) bad_wreg++;
            @(posedge clk); #1;
            reg1_i = $urandom; reg2_i = $urandom;
         end else begin
            done = 1;
         end
      end
      check($sformatf("div_done_op%02h", op), done, 1);
      check($sformatf("div_stalls_op%02h", op), stalls, exp_stalls);
      check($sformatf("div_wreg_stall_op%02h", op), bad_wreg, 0);
      check($sformatf("div_wdata_op%02h", op), wdata_o, exp);
      check($sformatf("div_wreg_end_op%02h", op), wreg_o, 1);
      @(posedge clk); #1;
      aluop_i = EXE_NOP_OP; alusel_i = EXE_RES_NOP;
   endtask
`endif

   initial begin
      sc_ops = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
                 EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP, EXE_SLTU_OP, EXE_JAL_OP, EXE_JALR_OP,
                 EXE_LW_OP, EXE_SW_OP, EXE_MUL_OP, EXE_MULH_OP, EXE_MULHSU_OP, EXE_MULHU_OP};
      rst = 1'b1; flush = 1'b0;
      aluop_i = EXE_ADD_OP; alusel_i = EXE_RES_ARITH; reg1_i = 32'h1234; reg2_i = 32'h1;
      wd_i = 5'd7; wreg_i = 1'b1; mem_ce_i = 1'b1; mem_sdata_i = 32'hDEAD; branch_link_addr_i = 32'h40;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wdata", wdata_o, 0);
      check("rst_wreg", wreg_o, 0);
      check("rst_stall", stallreq_o, 0);
      check("rst_addr", mem_addr_o, 0);
      check("rst_pass", {wd_o, mem_ce_o, aluop_o, mem_sdata_o}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      single(EXE_ADD_OP, 32'h7FFFFFFF, 32'h1);
      single(EXE_SLT_OP, 32'hFFFFFFFF, 32'h1);
      single(EXE_SLTU_OP, 32'hFFFFFFFF, 32'h1);
      single(EXE_SRA_OP, 32'h80000000, 32'h4);
      single(EXE_SW_OP, 32'h1000, 32'hFFFFFFFC);
      single(EXE_MULH_OP, 32'h80000000, 32'h80000000);
      single(EXE_MULHU_OP, 32'hFFFFFFFF, 32'h2);
      single(EXE_MUL_OP, 32'hFFFFFFFF, 32'hFFFFFFFF);
      single(EXE_MULHSU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF);
      for (int i = 0; i < 60; i++)
         single(sc_ops[$urandom_range(0, 17)], rand_val(), rand_val());

`ifdef MULDIV_EN
      run_div(EXE_DIV_OP, 32'd100, 32'hFFFFFFF9);
      run_div(EXE_REM_OP, 32'd100, 32'hFFFFFFF9);
      run_div(EXE_DIVU_OP, 32'd5, 32'd0);
      run_div(EXE_REMU_OP, 32'd5, 32'd0);
      run_div(EXE_DIV_OP, 32'hFFFFFFFB, 32'd0);
      run_div(EXE_DIV_OP, 32'h80000000, 32'hFFFFFFFF);
      run_div(EXE_REM_OP, 32'h80000000, 32'hFFFFFFFF);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] dops [4];
         dops = '{EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP};
         run_div(dops[i], rand_val(), rand_val());
      end
      // Abort a divide part-way through, then confirm a fresh divide is unaffected.
      @(posedge clk); #1;
      aluop_i = EXE_DIV_OP; alusel_i = EXE_RES_MULDIV; reg1_i = 32'd1000; reg2_i = 32'd3; wreg_i = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      check("pre_flush_stall", stallreq_o, 1);
      flush = 1'b1;
      #1;
      check("flush_stall", stallreq_o, 0);
      check("flush_wreg", wreg_o, 0);
      @(posedge clk); #1;
      flush = 1'b0; aluop_i = EXE_NOP_OP; alusel_i = EXE_RES_NOP;
      run_div(EXE_DIV_OP, 32'hFFFFFC18, 32'd7);
      run_div(EXE_REM_OP, 32'hFFFFFC18, 32'd7);
`else
      single(EXE_DIV_OP, 32'd100, 32'hFFFFFFF9);
      single(EXE_REMU_OP, 32'd5, 32'd0);
      single(EXE_DIVU_OP, 32'h80000000, 32'hFFFFFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
